// File: rtl/draw_frame_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the frame scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package draw_frame_scheduler_pkg;

    localparam int DEFAULT_SCREEN_W = 160;
    localparam int DEFAULT_SCREEN_H = 120;
    localparam int KEYBOARD_TOP_ROW = 92;

    localparam int COORD_W  = 8;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 24;

    typedef logic [COLOUR_W-1:0] colour_t;

    localparam colour_t COLOUR_BLACK = 24'h000000;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_NOTES = 2'd1,
        SCHED_KEYS  = 2'd2,
        SCHED_DONE  = 2'd3
    } sched_state_t;

    // Saturating 8-bit increment for event counters that must never wrap.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/draw_frame_scheduler_if.sv
// Bundle of frame request, renderer colour and VGA plot stream signals.
// Latency: n/a (wiring only).
// Backpressure: stall from the VGA adapter is carried alongside the plot stream.
interface draw_frame_scheduler_if;
    import draw_frame_scheduler_pkg::*;

    logic                 frameTick;
    logic                 notesEnable;
    logic                 stall;
    colour_t              noteColour;
    colour_t              keyColour;
    logic [COORD_W-1:0]   scanX;
    logic [COORD_W-1:0]   scanY;
    logic [ADDR_W-1:0]    noteAddress;
    logic [COORD_W-1:0]   vgaX;
    logic [COORD_W-1:0]   vgaY;
    colour_t              vgaColour;
    logic                 vgaPlot;
    logic                 busy;
    logic                 frameDone;
    logic [7:0]           overrunCount;

    // Scheduler side: owns scan position and the plot stream.
    modport master (
        input  frameTick, notesEnable, stall, noteColour, keyColour,
        output scanX, scanY, noteAddress, vgaX, vgaY, vgaColour, vgaPlot,
        busy, frameDone, overrunCount
    );

    // Environment side: frame requests, renderers and the VGA adapter.
    modport slave (
        output frameTick, notesEnable, stall, noteColour, keyColour,
        input  scanX, scanY, noteAddress, vgaX, vgaY, vgaColour, vgaPlot,
        busy, frameDone, overrunCount
    );

endinterface

// File: rtl/draw_frame_scheduler_scan.sv
// Pixel scan counter: raster x/y position plus linear address into the note buffer.
// Latency: position updates one cycle after advance; wrap flags are combinational.
// Backpressure: holds all counters whenever advance is low; clear wins over advance.
module draw_frame_scheduler_scan
    import draw_frame_scheduler_pkg::*;
#(
    parameter int SCREEN_W = DEFAULT_SCREEN_W,
    parameter int SCREEN_H = DEFAULT_SCREEN_H,
    parameter int KEY_TOP  = KEYBOARD_TOP_ROW
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               advance,
    input  logic               clear,
    output logic [COORD_W-1:0] scan_x,
    output logic [COORD_W-1:0] scan_y,
    output logic [ADDR_W-1:0]  scan_addr,
    output logic               last_pixel,
    output logic               last_note_row
);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               last_in_row;

    // Wrap flags: end of row, end of the note region, end of the frame.
    always_comb begin
        last_in_row   = (x_q == COORD_W'(SCREEN_W - 1));
        last_pixel    = last_in_row && (y_q == COORD_W'(SCREEN_H - 1));
        last_note_row = last_in_row && (y_q == COORD_W'(KEY_TOP - 1));
    end

    // Next position: the final pixel wraps straight back to (0,0) so the
    // counters already read zero in the cycle after the frame completes.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (advance) begin
            if (last_pixel) begin
                x_d    = '0;
                y_d    = '0;
                addr_d = '0;
            end else if (last_in_row) begin
                x_d    = '0;
                y_d    = y_q + COORD_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                x_d    = x_q + COORD_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign scan_x    = x_q;
    assign scan_y    = y_q;
    assign scan_addr = addr_q;

endmodule

// File: rtl/draw_frame_scheduler.sv
// Frame sequencer: scans every pixel once per frame tick, muxes note/keyboard colour into one plot stream.
// Latency: tick -> first scan position next cycle; issue -> vgaPlot exactly one cycle later.
// Backpressure: stall holds the scan for that cycle only; plot outputs are fully registered.
module draw_frame_scheduler
    import draw_frame_scheduler_pkg::*;
#(
    parameter int SCREEN_W = DEFAULT_SCREEN_W,
    parameter int SCREEN_H = DEFAULT_SCREEN_H,
    parameter int KEY_TOP  = KEYBOARD_TOP_ROW
) (
    input  logic                   clk,
    input  logic                   resetn,
    draw_frame_scheduler_if.master bus
);

    sched_state_t       state_q, state_d;
    logic               pending_q, pending_d;
    logic [7:0]         overrun_q, overrun_d;
    logic [COORD_W-1:0] vga_x_q, vga_x_d;
    logic [COORD_W-1:0] vga_y_q, vga_y_d;
    colour_t            vga_colour_q, vga_colour_d;
    logic               vga_plot_q, vga_plot_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;

    logic               scanning;
    logic               issue;
    logic               frame_start;
    colour_t            colour_sel;
    logic [COORD_W-1:0] scan_x;
    logic [COORD_W-1:0] scan_y;
    logic [ADDR_W-1:0]  scan_addr;
    logic               last_pixel;
    logic               last_note_row;

    // A pixel leaves the scanner whenever a frame is in progress and the adapter can take it.
    always_comb begin
        scanning = (state_q == SCHED_NOTES) || (state_q == SCHED_KEYS);
        issue    = scanning && !bus.stall;
    end

    draw_frame_scheduler_scan #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .KEY_TOP  (KEY_TOP)
    ) u_scan (
        .clk           (clk),
        .resetn        (resetn),
        .advance       (issue),
        .clear         (!scanning),
        .scan_x        (scan_x),
        .scan_y        (scan_y),
        .scan_addr     (scan_addr),
        .last_pixel    (last_pixel),
        .last_note_row (last_note_row)
    );

    // Colour select: note region goes black when notes are disabled (record mode).
    always_comb begin
        colour_sel = bus.keyColour;
        if (state_q == SCHED_NOTES) begin
            colour_sel = bus.notesEnable ? bus.noteColour : COLOUR_BLACK;
        end
    end

    // Next state, request buffering, overrun accounting and output-stage values.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        case (state_q)
            SCHED_IDLE: begin
                if (bus.frameTick || pending_q) begin
                    state_d     = SCHED_NOTES;
                    frame_start = 1'b1;
                end
            end
            SCHED_NOTES: begin
                if (issue && last_note_row) begin
                    state_d = SCHED_KEYS;
                end
            end
            SCHED_KEYS: begin
                if (issue && last_pixel) begin
                    state_d = SCHED_DONE;
                end
            end
            SCHED_DONE: begin
                // A waiting or coincident request restarts without an idle bubble.
                if (pending_q || bus.frameTick) begin
                    state_d     = SCHED_NOTES;
                    frame_start = 1'b1;
                end else begin
                    state_d = SCHED_IDLE;
                end
            end
            default: state_d = SCHED_IDLE;
        endcase

        // One request can wait; any further request while one waits is dropped and counted.
        overrun_d = overrun_q;
        if (bus.frameTick && pending_q && (state_q != SCHED_IDLE)) begin
            overrun_d = sat_inc8(overrun_q);
        end

        pending_d = pending_q;
        if (frame_start) begin
            pending_d = 1'b0;
        end else if (bus.frameTick && (state_q != SCHED_IDLE)) begin
            pending_d = 1'b1;
        end

        vga_plot_d   = issue;
        vga_x_d      = issue ? scan_x     : vga_x_q;
        vga_y_d      = issue ? scan_y     : vga_y_q;
        vga_colour_d = issue ? colour_sel : vga_colour_q;

        busy_d       = (state_d != SCHED_IDLE);
        frame_done_d = (state_d == SCHED_DONE);
    end

    // FSM and registered outputs; reset mid-frame drops the frame silently.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= SCHED_IDLE;
            pending_q    <= 1'b0;
            overrun_q    <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.scanX        = scan_x;
    assign bus.scanY        = scan_y;
    assign bus.noteAddress  = scan_addr;
    assign bus.vgaX         = vga_x_q;
    assign bus.vgaY         = vga_y_q;
    assign bus.vgaColour    = vga_colour_q;
    assign bus.vgaPlot      = vga_plot_q;
    assign bus.busy         = busy_q;
    assign bus.frameDone    = frame_done_q;
    assign bus.overrunCount = overrun_q;

endmodule

// File: tb/tb_draw_frame_scheduler.sv
// Directed/randomised bench for draw_frame_scheduler against a raster-order pixel model.
// Latency: checks tick->first plot and frame length on unstalled frames.
// Backpressure: random stall; every pixel must appear exactly once, in order, never after a stalled cycle.
module tb_draw_frame_scheduler;

    localparam int W = 160;
    localparam int H = 120;
    localparam int KT = 92;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic pattern_mode = 1'b0;
    int   checks = 0;
    int   errors = 0;

    draw_frame_scheduler_if bus_if ();

    draw_frame_scheduler dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    // Renderers: either fixed colours or a position-dependent pattern.
    assign bus_if.noteColour = pattern_mode ?
        {bus_if.scanX, bus_if.scanY, bus_if.scanX ^ bus_if.scanY} : 24'hFF0000;
    assign bus_if.keyColour  = pattern_mode ?
        {bus_if.scanY ^ 8'h3C, bus_if.scanX, 8'hC3} : 24'h00FF00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected colour of pixel (x,y) from the region rules.
    function automatic logic [23:0] exp_colour(input int x, input int y, input bit en, input bit pat);
        logic [7:0]  x8;
        logic [7:0]  y8;
        logic [23:0] note;
        logic [23:0] key;
        x8   = 8'(x);
        y8   = 8'(y);
        note = pat ? {x8, y8, x8 ^ y8} : 24'hFF0000;
        key  = pat ? {y8 ^ 8'h3C, x8, 8'hC3} : 24'h00FF00;
        if (y < KT) return en ? note : 24'h000000;
        return key;
    endfunction

    // Runs one frame from the negedge after its start edge. k counts plotted pixels;
    // the scan position must always equal k while the frame is in progress.
    task automatic run_frame(input int stall_pct, input bit en, input bit pat,
                             input int n_ticks, input int tick_start, input int tick_every,
                             input bit tick_at_done, input int stop_at, input bit reset_at_stop,
                             input bit strict_timing);
        int k = 0;
        int first_plot = -1;
        int done_cyc = -1;
        int ticks = 0;
        bit prev_stall = 1'b0;
        bit finished = 1'b0;
        bit stopped = 1'b0;
        logic [7:0] ex;
        logic [7:0] ey;
        bus_if.notesEnable = en;
        pattern_mode = pat;
        for (int cyc = 0; cyc < 40000 && !finished; cyc++) begin
            @(negedge clk);
            if (bus_if.vgaPlot) begin
                if (first_plot < 0) first_plot = cyc;
                ex = 8'(k % W);
                ey = 8'(k / W);
                check("plot", {prev_stall, bus_if.vgaX, bus_if.vgaY, bus_if.vgaColour},
                      {1'b0, ex, ey, exp_colour(k % W, k / W, en, pat)});
                k++;
            end
            if (bus_if.frameDone) begin
                finished = 1'b1;
                done_cyc = cyc;
                check("frame_done", {32'(k), bus_if.busy, bus_if.scanX, bus_if.scanY, bus_if.noteAddress},
                      {32'(NPIX), 1'b1, 8'd0, 8'd0, 15'd0});
                bus_if.frameTick = tick_at_done;
                bus_if.stall = 1'b0;
                prev_stall = 1'b0;
            end else begin
                check("scan_pos", {bus_if.frameDone, bus_if.busy, bus_if.scanX, bus_if.scanY, bus_if.noteAddress},
                      {1'b0, 1'b1, 8'(k % W), 8'(k / W), 15'(k)});
                if (stop_at >= 0 && k == stop_at) begin
                    stopped = 1'b1;
                    finished = 1'b1;
                    if (reset_at_stop) resetn = 1'b0;
                    bus_if.frameTick = 1'b0;
                    bus_if.stall = 1'b0;
                end else begin
                    bus_if.frameTick = 1'b0;
                    if (ticks < n_ticks && cyc >= tick_start && ((cyc - tick_start) % tick_every) == 0) begin
                        bus_if.frameTick = 1'b1;
                        ticks++;
                    end
                    bus_if.stall = ($urandom_range(99) < stall_pct);
                    prev_stall = bus_if.stall;
                end
            end
        end
        check("frame_bounded", {63'd0, finished}, 64'd1);
        if (strict_timing) begin
            check("first_plot_latency", 64'(first_plot), 64'd1);
            if (!stopped) check("frame_length", 64'(done_cyc), 64'(NPIX));
        end
    endtask

    initial begin
        bus_if.frameTick = 1'b0;
        bus_if.notesEnable = 1'b0;
        bus_if.stall = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus_if.vgaPlot, bus_if.vgaX, bus_if.vgaY, bus_if.vgaColour, bus_if.busy,
               bus_if.frameDone, bus_if.overrunCount},
              64'd0);
        check("reset_scan", {bus_if.scanX, bus_if.scanY, bus_if.noteAddress}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {bus_if.busy, bus_if.vgaPlot, bus_if.frameDone}, 64'd0);

        // Frame 1: unstalled, record mode, fixed colours; tick coincides with DONE.
        bus_if.notesEnable = 1'b0;
        bus_if.frameTick = 1'b1;
        run_frame(0, 1'b0, 1'b0, 0, 0, 1, 1'b1, -1, 1'b0, 1'b1);
        check("overrun_after_f1", 64'(bus_if.overrunCount), 64'd0);

        // Frame 2: started directly by the DONE-coincident tick; 30% stall,
        // three mid-frame ticks -> one buffered, two dropped.
        run_frame(30, 1'b1, 1'b1, 3, 100, 100, 1'b0, -1, 1'b0, 1'b0);
        check("overrun_two", 64'(bus_if.overrunCount), 64'd2);

        // Frame 3: started by the buffered request; 301 ticks saturate the counter.
        run_frame(0, 1'b1, 1'b1, 301, 50, 10, 1'b0, -1, 1'b0, 1'b1);
        check("overrun_saturate", 64'(bus_if.overrunCount), 64'd255);

        // Frame 4: buffered again; reset for one cycle at pixel (40,50).
        run_frame(0, 1'b1, 1'b0, 0, 0, 1, 1'b0, 50 * W + 40, 1'b1, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        check("midframe_reset_outputs",
              {bus_if.vgaPlot, bus_if.vgaX, bus_if.vgaY, bus_if.vgaColour, bus_if.busy,
               bus_if.frameDone, bus_if.overrunCount},
              64'd0);
        check("midframe_reset_scan", {bus_if.scanX, bus_if.scanY, bus_if.noteAddress}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_no_done", {bus_if.busy, bus_if.frameDone, bus_if.vgaPlot}, 64'd0);
        end

        // Frame 5: fresh tick restarts from (0,0); observe the first 200 pixels.
        bus_if.frameTick = 1'b1;
        run_frame(0, 1'b1, 1'b1, 0, 0, 1, 1'b0, 200, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
